// File: rtl/mdio_pkg.sv
// mdio_pkg: shared state encodings, opcodes and frame layout for the Clause-22 MDIO initiator.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_MDIO_M_IDLE,
        ST_MDIO_M_PRE,
        ST_MDIO_M_HDR,
        ST_MDIO_M_TA,
        ST_MDIO_M_DATA,
        ST_MDIO_M_DONE
    } mdio_state_e;

    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_TA       = 2'b10;

    localparam int unsigned FRAME_W      = 32;
    localparam int unsigned FRM_ST_LSB   = 30;
    localparam int unsigned FRM_OP_LSB   = 28;
    localparam int unsigned FRM_PHY_LSB  = 23;
    localparam int unsigned FRM_REG_LSB  = 18;
    localparam int unsigned FRM_TA_LSB   = 16;
    localparam int unsigned FRM_DATA_LSB = 0;

    localparam int unsigned HDR_BITS  = 14;
    localparam int unsigned TA_BITS   = 2;
    localparam int unsigned DATA_BITS = 16;

    // Frame image shifted out MSB first; read frames carry zero data (line is released anyway).
    function automatic logic [FRAME_W-1:0] mdio_build_frame(
        input logic        rd,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wr_data
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[FRM_ST_LSB   +: 2]  = MDIO_ST;
        f[FRM_OP_LSB   +: 2]  = rd ? MDIO_OP_READ : MDIO_OP_WRITE;
        f[FRM_PHY_LSB  +: 5]  = phyad;
        f[FRM_REG_LSB  +: 5]  = regad;
        f[FRM_TA_LSB   +: 2]  = MDIO_TA;
        f[FRM_DATA_LSB +: 16] = rd ? 16'h0000 : wr_data;
        return f;
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: divides sysclk into MDC and flags the cycle before each MDC edge.
module mdio_clk_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic reset,
    input  logic en_i,
    output logic mdc_o,
    output logic fall_tick_c,
    output logic rise_tick_c
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             mdc_q, mdc_d;
    logic             wrap_c;

    assign wrap_c      = en_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_tick_c = wrap_c && !mdc_q;
    assign fall_tick_c = wrap_c && mdc_q;
    assign mdc_o       = mdc_q;

    // Idle holds MDC low with the divider parked at zero so each frame starts on a full low half.
    always_comb begin
        div_d = div_q;
        mdc_d = mdc_q;
        if (!en_i) begin
            div_d = '0;
            mdc_d = 1'b0;
        end else if (wrap_c) begin
            div_d = '0;
            mdc_d = !mdc_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            div_q <= div_d;
            mdc_q <= mdc_d;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management initiator running complete read/write frames.
// Define MDIO_MASTER_TA_CHECK_EN to build the read turnaround check that drives ta_err.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        ta_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);
    localparam bit         HAS_PRE   = (PREAMBLE_LEN != 0);
    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
    localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

    mdio_state_e        state_q, state_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               is_read_q, is_read_d;
    logic [15:0]        rd_sh_q, rd_sh_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mdio_o_q, mdio_o_d;
    logic               mdio_t_q, mdio_t_d;
    logic               clk_en_c, fall_c, rise_c, start_acc_c, last_bit_c;

    assign clk_en_c    = state_q inside {ST_MDIO_M_PRE, ST_MDIO_M_HDR, ST_MDIO_M_TA, ST_MDIO_M_DATA};
    assign start_acc_c = (state_q == ST_MDIO_M_IDLE) && start;

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .sysclk      (sysclk),
        .reset       (reset),
        .en_i        (clk_en_c),
        .mdc_o       (mdc),
        .fall_tick_c (fall_c),
        .rise_tick_c (rise_c)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state_q <= ST_MDIO_M_IDLE;
        else        state_q <= state_d;
    end

    // Field transitions happen on the MDC falling edge that ends the field's last bit.
    always_comb begin
        state_d    = state_q;
        last_bit_c = 1'b0;
        case (state_q)
            ST_MDIO_M_IDLE: if (start_acc_c) state_d = HAS_PRE ? ST_MDIO_M_PRE : ST_MDIO_M_HDR;
            ST_MDIO_M_PRE: begin
                last_bit_c = (bit_cnt_q == PRE_LAST);
                if (fall_c && last_bit_c) state_d = ST_MDIO_M_HDR;
            end
            ST_MDIO_M_HDR: begin
                last_bit_c = (bit_cnt_q == HDR_LAST);
                if (fall_c && last_bit_c) state_d = ST_MDIO_M_TA;
            end
            ST_MDIO_M_TA: begin
                last_bit_c = (bit_cnt_q == TA_LAST);
                if (fall_c && last_bit_c) state_d = ST_MDIO_M_DATA;
            end
            ST_MDIO_M_DATA: begin
                last_bit_c = (bit_cnt_q == DATA_LAST);
                if (fall_c && last_bit_c) state_d = ST_MDIO_M_DONE;
            end
            ST_MDIO_M_DONE: state_d = ST_MDIO_M_IDLE;
            default:        state_d = ST_MDIO_M_IDLE;
        endcase
    end

    always_comb begin
        frame_d   = frame_q;
        is_read_d = is_read_q;
        bit_cnt_d = bit_cnt_q;
        rd_sh_d   = rd_sh_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mdio_o_d  = 1'b1;
        mdio_t_d  = 1'b1;
        case (state_q)
            ST_MDIO_M_IDLE: begin
                bit_cnt_d = '0;
                if (start_acc_c) begin
                    frame_d   = mdio_build_frame(rw, phy_addr, reg_addr, wdata);
                    is_read_d = rw;
                    busy_d    = 1'b1;
                    rd_sh_d   = '0;
                end
            end
            ST_MDIO_M_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (is_read_q) rdata_d = rd_sh_q;
            end
            default: begin
                if (fall_c) begin
                    bit_cnt_d = (state_d != state_q) ? 6'd0 : bit_cnt_q + 6'd1;
                    if (state_q != ST_MDIO_M_PRE) frame_d = frame_q << 1;
                end
                if (rise_c && (state_q == ST_MDIO_M_DATA) && is_read_q)
                    rd_sh_d = {rd_sh_q[14:0], mdio_i};
            end
        endcase
        // Pad drive follows the bit that starts on this edge; a released line idles high.
        case (state_d)
            ST_MDIO_M_PRE: mdio_t_d = 1'b0;
            ST_MDIO_M_HDR: begin
                mdio_t_d = 1'b0;
                mdio_o_d = frame_d[FRAME_W-1];
            end
            ST_MDIO_M_TA, ST_MDIO_M_DATA: begin
                mdio_t_d = is_read_d;
                mdio_o_d = is_read_d | frame_d[FRAME_W-1];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q <= '0;
            frame_q   <= '0;
            is_read_q <= 1'b0;
            rd_sh_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_t_q  <= 1'b1;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            is_read_q <= is_read_d;
            rd_sh_q   <= rd_sh_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mdio_o_q  <= mdio_o_d;
            mdio_t_q  <= mdio_t_d;
        end
    end

`ifdef MDIO_MASTER_TA_CHECK_EN
    logic ta_bad_q, ta_bad_d;
    logic ta_err_q, ta_err_d;

    // On a read the PHY must already be driving 0 during the second TA bit.
    always_comb begin
        ta_bad_d = ta_bad_q;
        ta_err_d = ta_err_q;
        if (start_acc_c) begin
            ta_bad_d = 1'b0;
            ta_err_d = 1'b0;
        end
        if (rise_c && (state_q == ST_MDIO_M_TA) && (bit_cnt_q == TA_LAST) && is_read_q)
            ta_bad_d = mdio_i;
        if ((state_q == ST_MDIO_M_DONE) && is_read_q)
            ta_err_d = ta_bad_q;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ta_bad_q <= 1'b0;
            ta_err_q <= 1'b0;
        end else begin
            ta_bad_q <= ta_bad_d;
            ta_err_q <= ta_err_d;
        end
    end

    assign ta_err = ta_err_q;
`else
    assign ta_err = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign mdio_o = mdio_o_q;
    assign mdio_t = mdio_t_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed frames against a PHY model with a scoreboard of expected frame results.
module tb_mdio_master;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysclk = ~sysclk;

`ifdef MDIO_MASTER_TA_CHECK_EN
    localparam bit TA_CHECK = 1'b1;
`else
    localparam bit TA_CHECK = 1'b0;
`endif

    logic        a_start = 1'b0, a_rw = 1'b0, a_mdio_i = 1'b1;
    logic [4:0]  a_phy = '0, a_reg = '0;
    logic [15:0] a_wdata = '0;
    logic        a_busy, a_done, a_ta_err, a_mdc, a_mdio_o, a_mdio_t;
    logic [15:0] a_rdata;

    logic        b_start = 1'b0, b_rw = 1'b0, b_mdio_i = 1'b1;
    logic [4:0]  b_phy = '0, b_reg = '0;
    logic [15:0] b_wdata = '0;
    logic        b_busy, b_done, b_ta_err, b_mdc, b_mdio_o, b_mdio_t;
    logic [15:0] b_rdata;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut_a (
        .sysclk(sysclk), .reset(reset), .start(a_start), .rw(a_rw),
        .phy_addr(a_phy), .reg_addr(a_reg), .wdata(a_wdata),
        .busy(a_busy), .done(a_done), .rdata(a_rdata), .ta_err(a_ta_err),
        .mdc(a_mdc), .mdio_o(a_mdio_o), .mdio_t(a_mdio_t), .mdio_i(a_mdio_i)
    );

    mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) u_dut_b (
        .sysclk(sysclk), .reset(reset), .start(b_start), .rw(b_rw),
        .phy_addr(b_phy), .reg_addr(b_reg), .wdata(b_wdata),
        .busy(b_busy), .done(b_done), .rdata(b_rdata), .ta_err(b_ta_err),
        .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_t(b_mdio_t), .mdio_i(b_mdio_i)
    );

    typedef struct {
        logic [63:0] o;
        logic [63:0] t;
        logic [15:0] rdata;
        logic        ta;
        int          lat;
        int          nbits;
    } exp_s;

    exp_s        sb[$];
    logic        cap_a_o[$], cap_a_t[$], cap_b_o[$], cap_b_t[$];
    int          n_vec = 0, n_err = 0;
    int          phy_k = 0;
    logic        phy_en = 1'b0;
    logic [15:0] phy_val = '0;
    logic [15:0] model_rdata = '0;
    int          a_done_cnt = 0, b_done_cnt = 0;

    // PHY model for a 32-bit preamble: TA bit 47 driven low, data on bits 48..63, pull-up elsewhere.
    function automatic logic phy_bit(input int k);
        if (!phy_en) return 1'b1;
        if (k == 47) return 1'b0;
        if (k >= 48 && k < 64) return phy_val[63 - k];
        return 1'b1;
    endfunction

    always @(posedge a_mdc) begin
        cap_a_o.push_back(a_mdio_o);
        cap_a_t.push_back(a_mdio_t);
        phy_k    = phy_k + 1;
        a_mdio_i = phy_bit(phy_k);
    end

    always @(posedge b_mdc) begin
        cap_b_o.push_back(b_mdio_o);
        cap_b_t.push_back(b_mdio_t);
    end

    always @(negedge sysclk) begin
        if (a_done) a_done_cnt = a_done_cnt + 1;
        if (b_done) b_done_cnt = b_done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec = n_vec + 1;
        assert (obs === exp_v) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic run_a(input logic rw, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input logic drive, input logic [15:0] pval,
                         input int restart_at);
        exp_s        e;
        logic [63:0] obs_o, obs_t;
        int          cyc, d0;
        e.t     = rw ? 64'h3_ffff : 64'h0;
        e.o     = {32'hffff_ffff, 2'b01, (rw ? 2'b10 : 2'b01), phy, rg, 2'b10, wd};
        if (rw) model_rdata = drive ? pval : 16'hffff;
        e.rdata = model_rdata;
        e.ta    = rw && !drive && TA_CHECK;
        e.lat   = 64 * 2 * 2 + 2;
        e.nbits = 64;
        sb.push_back(e);

        cap_a_o.delete();
        cap_a_t.delete();
        phy_k    = 0;
        phy_en   = drive;
        phy_val  = pval;
        a_mdio_i = 1'b1;
        d0       = a_done_cnt;
        @(posedge sysclk); #1;
        a_rw = rw; a_phy = phy; a_reg = rg; a_wdata = wd; a_start = 1'b1;
        @(posedge sysclk); #1;
        a_start = 1'b0;
        cyc     = 1;
        chk("busy_after_start", 64'(a_busy), 64'd1);
        chk("ta_err_cleared", 64'(a_ta_err), 64'd0);
        while (!a_done && cyc < 5000) begin
            a_start = (cyc == restart_at);
            if (cyc == restart_at) begin
                a_wdata = ~wd;
                a_rw    = ~rw;
            end
            @(posedge sysclk); #1;
            cyc = cyc + 1;
        end
        a_start = 1'b0;

        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.lat));
        chk("busy_at_done", 64'(a_busy), 64'd0);
        chk("rdata", 64'(a_rdata), 64'(e.rdata));
        chk("ta_err", 64'(a_ta_err), 64'(e.ta));
        chk("nbits", 64'(cap_a_o.size()), 64'(e.nbits));
        obs_o = '0;
        obs_t = '0;
        for (int i = 0; i < cap_a_o.size() && i < 64; i++) begin
            obs_o[63 - i] = cap_a_o[i];
            obs_t[63 - i] = cap_a_t[i];
        end
        chk("stream_o", obs_o | e.t, e.o | e.t);
        chk("stream_t", obs_t, e.t);
        repeat (12) @(posedge sysclk);
        #1;
        chk("done_pulses", 64'(a_done_cnt - d0), 64'd1);
        chk("mdc_idle", 64'(a_mdc), 64'd0);
        chk("mdio_t_idle", 64'(a_mdio_t), 64'd1);
    endtask

    initial begin
        exp_s        e;
        logic [63:0] obs_o, obs_t;
        int          cyc, d0;

        // Reset values
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_mdc", 64'(a_mdc), 64'd0);
        chk("rst_mdio_o", 64'(a_mdio_o), 64'd1);
        chk("rst_mdio_t", 64'(a_mdio_t), 64'd1);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_ta_err", 64'(a_ta_err), 64'd0);
        chk("rst_rdata", 64'(a_rdata), 64'd0);
        chk("rst_b_mdc", 64'(b_mdc), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge sysclk);

        run_a(1'b0, 5'd1, 5'd0, 16'h1040, 1'b0, 16'h0000, -1);
        run_a(1'b1, 5'd1, 5'd1, 16'h0000, 1'b1, 16'h79ad, -1);
        run_a(1'b0, 5'd3, 5'd4, 16'ha5c3, 1'b0, 16'h0000, 10);
        run_a(1'b1, 5'd2, 5'd1, 16'h0000, 1'b0, 16'h0000, -1);
        run_a(1'b1, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h0141, -1);

        // Reset while a read is in its DATA field, with MDC high
        cap_a_o.delete();
        cap_a_t.delete();
        phy_k = 0; phy_en = 1'b1; phy_val = 16'h1234; a_mdio_i = 1'b1;
        @(posedge sysclk); #1;
        a_rw = 1'b1; a_phy = 5'd1; a_reg = 5'd3; a_start = 1'b1;
        @(posedge sysclk); #1;
        a_start = 1'b0;
        repeat (219) @(posedge sysclk);
        #1;
        chk("mid_mdc_high", 64'(a_mdc), 64'd1);
        chk("mid_released", 64'(a_mdio_t), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_mdc", 64'(a_mdc), 64'd0);
        chk("mid_rst_mdio_t", 64'(a_mdio_t), 64'd1);
        chk("mid_rst_mdio_o", 64'(a_mdio_o), 64'd1);
        chk("mid_rst_busy", 64'(a_busy), 64'd0);
        chk("mid_rst_rdata", 64'(a_rdata), 64'd0);
        model_rdata = 16'h0000;
        repeat (3) @(posedge sysclk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge sysclk);
        #1;
        chk("post_rst_busy", 64'(a_busy), 64'd0);
        run_a(1'b1, 5'd1, 5'd1, 16'h0000, 1'b1, 16'h79ad, -1);

        // Preamble-less, fastest-MDC instance: 32-bit write frame
        e.o     = {32'h0, 2'b01, 2'b01, 5'd5, 5'd31, 2'b10, 16'hbeef};
        e.t     = 64'h0;
        e.rdata = 16'h0000;
        e.ta    = 1'b0;
        e.lat   = 32 * 2 * 1 + 2;
        e.nbits = 32;
        sb.push_back(e);
        cap_b_o.delete();
        cap_b_t.delete();
        d0 = b_done_cnt;
        @(posedge sysclk); #1;
        b_rw = 1'b0; b_phy = 5'd5; b_reg = 5'd31; b_wdata = 16'hbeef; b_start = 1'b1;
        @(posedge sysclk); #1;
        b_start = 1'b0;
        cyc     = 1;
        while (!b_done && cyc < 5000) begin
            @(posedge sysclk); #1;
            cyc = cyc + 1;
        end
        e = sb.pop_front();
        chk("b_latency", 64'(cyc), 64'(e.lat));
        chk("b_nbits", 64'(cap_b_o.size()), 64'(e.nbits));
        obs_o = '0;
        obs_t = '0;
        for (int i = 0; i < cap_b_o.size() && i < 32; i++) begin
            obs_o[31 - i] = cap_b_o[i];
            obs_t[31 - i] = cap_b_t[i];
        end
        chk("b_first_bit", 64'(obs_o[31]), 64'd0);
        chk("b_stream_o", obs_o, e.o);
        chk("b_stream_t", obs_t, e.t);
        chk("b_rdata", 64'(b_rdata), 64'(e.rdata));
        repeat (5) @(posedge sysclk);
        #1;
        chk("b_done_pulses", 64'(b_done_cnt - d0), 64'd1);
        chk("b_busy_idle", 64'(b_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO management initiator (station management side) that runs complete read/write frames to an external or virtual Ethernet PHY.
- Generates MDC and drives `mdio_o`/`mdio_t` into a tri-state pad; samples `mdio_i`.
- Controlled by a single-cycle command strobe from the Ethernet control register logic.
- Returns the read data, a busy/done handshake and a turnaround-error flag.

Parameters:
- CLK_DIV, 25, sysclk cycles per MDC half-period; MDC = sysclk/(2*CLK_DIV); must be >= 1.
- PREAMBLE_LEN, 32, number of preamble 1-bits sent before ST; range 0..32.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe; accepted only when busy=0
- rw  in  1  1 = read (OP 10), 0 = write (OP 01)
- phy_addr  in  5  PHYAD
- reg_addr  in  5  REGAD
- wdata  in  16  write data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- rdata  out  16  last read data; held until the next read completes
- ta_err  out  1  read turnaround check failed on the last read
- mdc  out  1  management clock
- mdio_o  out  1  data driven to pad
- mdio_t  out  1  tri-state control; 1 = released (input)
- mdio_i  in  1  data from pad

Behaviour:
- Clock/reset: one clock, sysclk. reset is asynchronous, active-low; all flops use posedge sysclk or negedge reset.
- Reset values:
  - mdc=0, mdio_o=1, mdio_t=1, busy=0, done=0, ta_err=0, rdata=0.
  - State=IDLE, divider=0, bit counter=0.
- Command capture:
  - In IDLE, start=1 latches rw/phy_addr/reg_addr/wdata into a 32-bit frame shift register: {01, OP, PHYAD, REGAD, TA, DATA}.
  - TA = 10 for writes; for reads, DATA=0.
  - busy=1 from the next cycle.
  - start while busy=1 is ignored; no queueing.
- Bit timing:
  - Each MDC bit is 2*CLK_DIV sysclk cycles: low half, then high half.
  - mdio_o/mdio_t update on the cycle MDC goes 0, which is the start of the bit.
  - mdio_i is sampled on the cycle MDC goes 0->1, using the value present just before the rising edge.
- States:
  - IDLE.
  - PRE: PREAMBLE_LEN bits, mdio_o=1, mdio_t=0; skipped when PREAMBLE_LEN=0.
  - HDR: 14 bits ST, OP, PHYAD, REGAD, MSB first, driven.
  - TA: 2 bits.
    - Write: drive 1 then 0.
    - Read: mdio_t=1 for both bits.
  - DATA: 16 bits.
    - Write: drive wdata MSB first.
    - Read: mdio_t=1; shift in mdio_i MSB first.
  - DONE: one cycle; done=1, busy=0 next cycle; read loads rdata; returns to IDLE.
- Latency: start to done pulse = (PREAMBLE_LEN+32)*2*CLK_DIV + 2 cycles; default 128*25+2 = 3202.
- Idle line state: mdc held low; mdio_t=1; mdio_o=1.
- Writes never modify rdata; rdata changes only in DONE of a read.
- Reset mid-frame: immediate return to reset values; a partial frame is abandoned, and the PHY resynchronises on the next preamble.
- Divider and bit counter wrap cleanly; the bit counter is 6 bits (0..63).

Optional Feature:
- Macro: MDIO_MASTER_TA_CHECK_EN.
- When defined:
  - During a read, mdio_i sampled on the second TA bit must be 0 (PHY driving).
  - If mdio_i is 1, ta_err=1 is latched in DONE and rdata is still updated with the sampled bits.
  - ta_err is cleared by the next accepted start.
- When undefined: ta_err is tied 0 and no TA sampling logic is built.

Decomposition:
- Shared package mdio_pkg:
  - State encodings (ST_MDIO_M_IDLE/PRE/HDR/TA/DATA/DONE).
  - OP constants MDIO_OP_READ=2'b10, MDIO_OP_WRITE=2'b01, ST pattern 2'b01.
  - Frame-field bit positions.
- One natural sub-module: mdio_clk_gen, the CLK_DIV counter producing mdc plus one-cycle fall_tick/rise_tick strobes.

Test Plan:
- Write, CLK_DIV=2, phy_addr=1, reg_addr=0, wdata=16'h1040 -> captured serial stream = 32 ones then 0101_00001_00000_10_0001000001000000; mdio_t=0 throughout; done at cycle 258.
- Read reg 1 from a bench PHY model returning 16'h79ad -> mdio_t=1 for the final 18 bits; rdata=16'h79ad; ta_err=0.
- Read with the bench PHY not driving (pull-up, mdio_i=1) and MDIO_MASTER_TA_CHECK_EN defined -> rdata=16'hffff, ta_err=1; next start clears ta_err.
- start pulsed again at cycle 10 of a frame -> ignored; exactly one done pulse; serial stream unchanged.
- reset deasserted-low mid-DATA -> mdc=0, mdio_t=1, busy=0 immediately; a following read completes normally.
- PREAMBLE_LEN=0, CLK_DIV=1 -> first driven bit is ST=0; frame is 32 bits; done at cycle 66.
